// File: rtl/uart_tx_regs.sv
// UART peripheral: control/data registers plus an 8N1 transmitter on tx_o.
// Define UART_RX_EN to build the receiver, which updates data and sets ctrl bit1.
module uart_tx_regs #(
  parameter int unsigned BAUD_DIV = 10416,
  parameter int unsigned CNT_W    = $clog2(BAUD_DIV)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_ctrl_uart_i,
  input  logic        we_data_uart_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ctrl_o,
  output logic [31:0] data_o,
  output logic        tx_o,
  input  logic        rx_i
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             send_q, send_d;
  logic             tx_q, tx_d;
  logic             baud_wrap;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tx_state_d = tx_state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    send_d     = send_q;
    tx_d       = tx_q;
    baud_wrap  = (baud_cnt_q == BAUD_LAST);

    if (tx_state_q != TX_IDLE) begin
      baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + CNT_W'(1);
    end

    // tx_d tracks the level of the state being entered, so tx_o changes with the state.
    unique case (tx_state_q)
      TX_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (send_q) begin
          tx_state_d = TX_START;
          shift_d    = data_q;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (baud_wrap) begin
          tx_state_d = TX_DATA;
          bit_idx_d  = 3'd0;
          tx_d       = shift_q[0];
        end
      end
      TX_DATA: begin
        if (baud_wrap) begin
          if (bit_idx_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (baud_wrap) begin
          tx_state_d = TX_IDLE;
          send_d     = 1'b0;
          tx_d       = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (tx_state_q == TX_IDLE && we_ctrl_uart_i && wdata_i[0]) begin
      send_d = 1'b1;
    end
  end

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_HALF, RX_DATA, RX_STOP} rx_state_e;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [2:0]       rx_sync_q, rx_sync_d;
  logic             rx_new_q, rx_new_d;
  logic             rx_line, rx_fall, rx_load;
  logic             unused_in;

  assign unused_in = ^wdata_i[31:8];

  // Bits [1:0] are the synchroniser; bit 2 is the previous synced level for edge detect.
  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], rx_i};
    rx_line    = rx_sync_q[1];
    rx_fall    = rx_sync_q[2] & ~rx_sync_q[1];
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_HALF;
      end
      RX_HALF: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = 3'd0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_load    = rx_line;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    rx_new_d = rx_new_q;
    if (we_ctrl_uart_i && !wdata_i[1]) rx_new_d = 1'b0;
    if (rx_load)                       rx_new_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_sync_q  <= 3'b111;
      rx_new_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_sync_q  <= rx_sync_d;
      rx_new_q   <= rx_new_d;
    end
  end

  assign ctrl_o = {30'd0, rx_new_q, send_q};
`else
  logic unused_in;

  assign unused_in = ^{wdata_i[31:8], wdata_i[1], rx_i};
  assign ctrl_o    = {30'd0, 1'b0, send_q};
`endif

  always_comb begin
    data_d = data_q;
    if (we_data_uart_i) data_d = wdata_i[7:0];
`ifdef UART_RX_EN
    // A received byte overrides a CPU write on the same edge.
    if (rx_load) data_d = rx_shift_q;
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      send_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      send_q     <= send_d;
      tx_q       <= tx_d;
    end
  end

  assign data_o = {24'd0, data_q};
  assign tx_o   = tx_q;

endmodule

// File: tb/tb_uart_tx_regs.sv
// Self-checking bench for uart_tx_regs at BAUD_DIV=16: register vectors, TX frames, RX paths.
module tb_uart_tx_regs;
  localparam int BAUD = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        we_ctrl_uart_i;
  logic        we_data_uart_i;
  logic [31:0] wdata_i;
  logic [31:0] ctrl_o;
  logic [31:0] data_o;
  logic        tx_o;
  logic        rx_i;

  uart_tx_regs #(.BAUD_DIV(BAUD)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .we_ctrl_uart_i (we_ctrl_uart_i),
    .we_data_uart_i (we_data_uart_i),
    .wdata_i        (wdata_i),
    .ctrl_o         (ctrl_o),
    .data_o         (data_o),
    .tx_o           (tx_o),
    .rx_i           (rx_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wc;
    logic        wd;
    logic [31:0] wdata;
    logic [31:0] exp_ctrl;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] reg_sb[$];
  logic        tx_sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_bus();
    we_ctrl_uart_i = 1'b0;
    we_data_uart_i = 1'b0;
    wdata_i        = 32'h0;
  endtask

  // Issues a send and checks the whole frame cycle by cycle against the scoreboard.
  task automatic run_frame(input logic [7:0] exp_byte, input bit busy_writes, input int rst_at);
    int bad;
    int quiet_bad;
    int k;
    logic exp_bit;
    tx_sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_sb.push_back(exp_byte[i]);
    tx_sb.push_back(1'b1);

    we_ctrl_uart_i = 1'b1;
    wdata_i        = 32'h1;
    tick();
    clear_bus();
    check("send_set", {31'd0, ctrl_o[0]}, 32'h1);
    tick();

    for (int b = 0; b < 10; b++) begin
      exp_bit = tx_sb.pop_front();
      bad = 0;
      for (int c = 0; c < BAUD; c++) begin
        k = b * BAUD + c;
        if (tx_o !== exp_bit) bad++;
        if (k == 10 * BAUD - 1) check("send_held", {31'd0, ctrl_o[0]}, 32'h1);
        if (rst_at == k) begin
          check($sformatf("tx_bit%0d_pre_rst", b), bad, 0);
          rst_i = 1'b1;
          tick();
          rst_i = 1'b0;
          check("rst_mid_tx", {31'd0, tx_o}, 32'h1);
          check("rst_mid_ctrl", ctrl_o, 32'h0);
          check("rst_mid_data", data_o, 32'h0);
          quiet_bad = 0;
          for (int q = 0; q < 200; q++) begin
            if (tx_o !== 1'b1) quiet_bad++;
            tick();
          end
          check("rst_mid_quiet", quiet_bad, 0);
          check("rst_mid_ctrl_after", ctrl_o, 32'h0);
          tx_sb.delete();
          return;
        end
        if (busy_writes && k == 40) begin
          we_data_uart_i = 1'b1;
          wdata_i        = 32'h3C;
        end else if (busy_writes && k == 41) begin
          we_data_uart_i = 1'b0;
          we_ctrl_uart_i = 1'b1;
          wdata_i        = 32'h0;
        end else if (busy_writes && k == 42) begin
          clear_bus();
        end
        tick();
      end
      check($sformatf("tx_bit%0d", b), bad, 0);
    end
    check("send_clear", {31'd0, ctrl_o[0]}, 32'h0);
    check("tx_idle", {31'd0, tx_o}, 32'h1);
    if (busy_writes) check("busy_data", data_o, 32'h3C);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (BAUD) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BAUD) tick();
    end
    rx_i = stop_bit;
    repeat (BAUD) tick();
    rx_i = 1'b1;
    repeat (20) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    vecs[0] = '{1'b0, 1'b1, 32'h000000A5, 32'h0, 32'hA5};
    vecs[1] = '{1'b0, 1'b1, 32'hFFFFFF3C, 32'h0, 32'h3C};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h3C};
    vecs[3] = '{1'b0, 1'b1, 32'h12345678, 32'h0, 32'h78};
    vecs[4] = '{1'b1, 1'b0, 32'h00000002, 32'h0, 32'h78};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h78};
    vecs[6] = '{1'b0, 1'b1, 32'h00000000, 32'h0, 32'h00};
    vecs[7] = '{1'b0, 1'b1, 32'h000000A5, 32'h0, 32'hA5};

    rst_i = 1'b1;
    rx_i  = 1'b1;
    clear_bus();
    repeat (3) tick();
    check("reset_tx", {31'd0, tx_o}, 32'h1);
    check("reset_ctrl", ctrl_o, 32'h0);
    check("reset_data", data_o, 32'h0);
    rst_i = 1'b0;
    tick();

    foreach (vecs[i]) begin
      we_ctrl_uart_i = vecs[i].wc;
      we_data_uart_i = vecs[i].wd;
      wdata_i        = vecs[i].wdata;
      reg_sb.push_back({vecs[i].exp_ctrl, vecs[i].exp_data});
      tick();
      clear_bus();
      e = reg_sb.pop_front();
      check($sformatf("vec%0d_ctrl", i), ctrl_o, e[63:32]);
      check($sformatf("vec%0d_data", i), data_o, e[31:0]);
    end

    run_frame(8'hA5, 1'b0, -1);
    run_frame(8'hA5, 1'b1, -1);
    run_frame(8'h3C, 1'b0, -1);
    run_frame(8'h3C, 1'b0, 50);

`ifdef UART_RX_EN
    send_rx(8'h5A, 1'b1);
    check("rx_data", data_o, 32'h5A);
    check("rx_ctrl", ctrl_o, 32'h2);
    we_ctrl_uart_i = 1'b1;
    wdata_i        = 32'h0;
    tick();
    clear_bus();
    check("rx_new_clear", ctrl_o, 32'h0);
    rx_i = 1'b0;
    repeat (4) tick();
    rx_i = 1'b1;
    repeat (200) tick();
    check("glitch_data", data_o, 32'h5A);
    check("glitch_ctrl", ctrl_o, 32'h0);
    send_rx(8'h77, 1'b0);
    check("frame_err_data", data_o, 32'h5A);
    check("frame_err_ctrl", ctrl_o, 32'h0);
    send_rx(8'hC3, 1'b1);
    check("rx2_data", data_o, 32'hC3);
    check("rx2_ctrl", ctrl_o, 32'h2);
`else
    we_data_uart_i = 1'b1;
    wdata_i        = 32'h99;
    tick();
    clear_bus();
    check("norx_pre_data", data_o, 32'h99);
    send_rx(8'h5A, 1'b1);
    check("norx_data", data_o, 32'h99);
    check("norx_ctrl", ctrl_o, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
